inst_prefetch_queue: RTL

//  Instruction prefetch queue that sits directly upstream of the pipelined core's IF/ID register.
//  - Owns the fetch PC.
//  - Issues word reads to a variable-latency instruction memory over a req/ack handshake.
//  - Buffers up to DEPTH fetched {PC, instruction} pairs.
//  - Presents the oldest pair to IF with valid/ready.
//  - Flushes and re-steers when the MEM stage resolves a taken branch (PCSrc/target).

---
 rtl/ipq_pkg.sv | 14 +
 rtl/inst_prefetch_queue_if.sv | 31 +++
 rtl/ipq_fifo.sv | 56 +++++
 rtl/inst_prefetch_queue.sv | 109 ++++++++++
 4 files changed

// File: rtl/ipq_pkg.sv
// rtl/ipq_pkg.sv - shared types and defaults for the instruction prefetch queue
package ipq_pkg;

    localparam int IPQ_DEPTH   = 4;
    localparam int IPQ_ADDR_W  = 64;
    localparam int IPQ_INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } ipq_state_e;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// rtl/inst_prefetch_queue_if.sv - instruction memory and IF-stage handshake bundle
interface inst_prefetch_queue_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  if_pc4;

    // master: the prefetch queue; slave: memory plus IF stage
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_instr, if_pc, if_pc4,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_instr, if_pc, if_pc4,
        output if_ready
    );
endinterface

// File: rtl/ipq_fifo.sv
// rtl/ipq_fifo.sv - DEPTH-entry {pc, instr} storage with head read and flush
module ipq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 96,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          CLK,
    input  logic          Reset_L,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            // flush wins over any push/pop on the same edge
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head is read straight from storage so a pop exposes the next entry without a bubble
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - fetch PC owner, imem request FSM and prefetch buffer
module inst_prefetch_queue
    import ipq_pkg::*;
#(
    parameter int DEPTH   = IPQ_DEPTH,
    parameter int ADDR_W  = IPQ_ADDR_W,
    parameter int INSTR_W = IPQ_INSTR_W
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic [ADDR_W-1:0] startPC,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectPC,
    inst_prefetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + INSTR_W;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    ipq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;

    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic              push;
    logic              pop;
    logic              space;
    logic [CW:0]       occ_next;

    assign pop      = bus.if_valid & bus.if_ready;
    assign push     = (state_q == REQ) & bus.imem_ack & ~redirect;
    assign occ_next = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, push};
    assign space    = occ_next < DEPTH_C;

    ipq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .push    (push),
        .pop     (pop),
        .clear   (redirect),
        .wdata_i ({fpc_q, bus.imem_rdata}),
        .head_o  (head),
        .count_o (count)
    );

    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q     <= IDLE;
            fpc_q       <= startPC;
            disc_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        disc_addr_d = disc_addr_q;
        if (redirect) begin
            fpc_d = redirectPC;
            case (state_q)
                REQ: begin
                    if (bus.imem_ack) begin
                        state_d = IDLE;
                    end else begin
                        // remember the abandoned address so the bus stays stable until ack
                        state_d     = DISCARD;
                        disc_addr_d = fpc_q;
                    end
                end
                DISCARD: state_d = bus.imem_ack ? IDLE : DISCARD;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (space) state_d = REQ;
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        fpc_d   = fpc_q + ADDR_W'(4);
                        state_d = space ? REQ : IDLE;
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.imem_req  = (state_q != IDLE);
    assign bus.imem_addr = (state_q == DISCARD) ? disc_addr_q : fpc_q;

    assign bus.if_valid  = (count != '0);
    assign bus.if_pc     = head[EW-1 -: ADDR_W];
    assign bus.if_instr  = head[INSTR_W-1:0];
    assign bus.if_pc4    = bus.if_pc + ADDR_W'(4);

endmodule
